// File: rtl/dmem_bus_adapter_if.sv
// Data-memory bus between dmem_bus_adapter (master) and the memory (slave).
//
// Request channel (valid/ready): the master raises bus_req_valid with
// addr/we/be/wdata stable and holds all of them until a cycle in which
// bus_req_ready is also high; that cycle is the handshake. Read response:
// bus_rsp_valid qualifies bus_rdata for one cycle, has no ready, and is
// only meaningful on or after the read handshake.
interface dmem_bus_adapter_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    logic            bus_req_valid;
    logic            bus_req_ready;
    logic [ALEN-1:0] bus_addr;
    logic            bus_we;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_rsp_valid;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rdata
    );
endinterface

// File: rtl/dmem_bus_adapter.sv
// MEM-stage to data-memory bus adapter: turns each load/store into one
// valid/ready transaction, stalls the pipeline until it completes, lane-
// shifts store data, aligns and extends load data, and aborts with a
// bus_error pulse after TIMEOUT_CYCLES.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned LH/LHU/SH/LW/SW
// without touching the bus). Undefined: no alignment check.
// dbg_state_o exposes the FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE, 4 MISAL).
module dmem_bus_adapter #(
    parameter int XLEN           = 32,
    parameter int ALEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                dmem_we,
    input  logic [ALEN-1:0]     dmem_addr,
    input  logic [XLEN-1:0]     dmem_wdata,
    input  logic [3:0]          dmem_be,
    input  logic [2:0]          dmem_funct3,
    output logic                mem_stall,
    output logic [XLEN-1:0]     load_data,
    output logic                access_done,
    output logic                bus_error,
    output logic [2:0]          dbg_state_o,
    dmem_bus_adapter_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_DONE  = 3'd3,
        S_MISAL = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] load_q, load_d;
    logic            req;
    logic            misalign;
    logic            timeout;
    logic            valid_c, done_c, err_c;

    // Select the addressed byte/half of a read word and extend it per funct3.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                                input logic [1:0]      off,
                                                input logic [2:0]      f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        case (f3)
            3'b000:  extract = {{(XLEN-8){b[7]}}, b};
            3'b001:  extract = {{(XLEN-16){h[15]}}, h};
            3'b010:  extract = w;
            3'b100:  extract = {{(XLEN-8){1'b0}}, b};
            3'b101:  extract = {{(XLEN-16){1'b0}}, h};
            default: extract = '0;
        endcase
    endfunction

    assign req = mem_read | dmem_we;

    // Flag accesses whose address does not fit their size.
    always_comb begin
        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (dmem_funct3)
            3'b001, 3'b101: misalign = dmem_addr[0];
            3'b010:         misalign = (dmem_addr[1:0] != 2'b00);
            default:        misalign = 1'b0;
        endcase
`endif
    end

    // The counter only ever climbs to TIMEOUT_CYCLES, where the abort fires.
    assign timeout = ((state_q == S_REQ) || (state_q == S_RESP)) &&
                     (cnt_q == CW'(TIMEOUT_CYCLES));

    // Next-state, timeout counter, load capture and per-cycle pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        valid_c = 1'b0;
        done_c  = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (misalign) begin
                        state_d = S_MISAL;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                if (timeout) begin
                    err_c   = 1'b1;
                    done_c  = 1'b1;
                    load_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    valid_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (bus.bus_req_ready) begin
                        if (dmem_we) begin
                            // A store completes in its handshake cycle.
                            done_c  = 1'b1;
                            state_d = S_IDLE;
                        end else if (bus.bus_rsp_valid) begin
                            load_d  = extract(bus.bus_rdata, dmem_addr[1:0], dmem_funct3);
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RESP;
                        end
                    end
                end
            end
            S_RESP: begin
                if (timeout) begin
                    err_c   = 1'b1;
                    done_c  = 1'b1;
                    load_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.bus_rsp_valid) begin
                        load_d  = extract(bus.bus_rdata, dmem_addr[1:0], dmem_funct3);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            S_MISAL: begin
                done_c  = 1'b1;
                err_c   = 1'b1;
                load_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and load-result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    // Pulses are suppressed in a reset cycle so an aborted access reports nothing.
    assign access_done       = done_c & ~rst;
    assign bus_error         = err_c & ~rst;
    assign load_data         = bus_error ? '0 : load_q;
    assign mem_stall         = req & ~access_done;
    assign dbg_state_o       = state_q;

    // Stores win when both request lines are high.
    assign bus.bus_req_valid = valid_c & ~rst;
    assign bus.bus_addr      = {dmem_addr[ALEN-1:2], 2'b00};
    assign bus.bus_we        = dmem_we;
    assign bus.bus_be        = dmem_we ? dmem_be : 4'b1111;

    // Replicate store data across lanes so the byte enables pick the target.
    always_comb begin
        case (dmem_funct3[1:0])
            2'b00:   bus.bus_wdata = {4{dmem_wdata[7:0]}};
            2'b01:   bus.bus_wdata = {2{dmem_wdata[15:0]}};
            default: bus.bus_wdata = dmem_wdata;
        endcase
    end
endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter (TIMEOUT_CYCLES=8).
module tb_dmem_bus_adapter;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [2:0]  dmem_funct3;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        access_done;
    logic        bus_error;
    logic [2:0]  dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_bus_adapter_if #(.XLEN(32), .ALEN(32)) bus_if ();

    dmem_bus_adapter #(.XLEN(32), .ALEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_funct3 (dmem_funct3),
        .mem_stall   (mem_stall),
        .load_data   (load_data),
        .access_done (access_done),
        .bus_error   (bus_error),
        .dbg_state_o (dbg_state),
        .bus         (bus_if)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Driver helpers: inputs change 1ns after the rising edge, outputs are read on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        mem_read              = 1'b0;
        dmem_we               = 1'b0;
        dmem_addr             = '0;
        dmem_wdata            = '0;
        dmem_be               = '0;
        dmem_funct3           = '0;
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_rsp_valid  = 1'b0;
        bus_if.bus_rdata      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        sample();
        tests_run++;
        if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        tests_run++;
        if (bus_if.bus_req_valid !== 1'b0 || access_done !== 1'b0 || bus_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses: valid=%b done=%b err=%b want 0 0 0", bus_if.bus_req_valid, access_done, bus_error);
        end
        tests_run++;
        if (load_data !== 32'h0 || mem_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_load: load=%h stall=%b want 0 0", load_data, mem_stall);
        end
    endtask

    task automatic test_store_word();
        next_cycle();
        dmem_we = 1'b1; dmem_addr = 32'h100; dmem_wdata = 32'hDEADBEEF; dmem_be = 4'b1111;
        dmem_funct3 = 3'b010; bus_if.bus_req_ready = 1'b1;
        sample();
        tests_run++;
        if (mem_stall !== 1'b1 || bus_if.bus_req_valid !== 1'b0 || access_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_cycle0: stall=%b valid=%b done=%b want 1 0 0", mem_stall, bus_if.bus_req_valid, access_done);
        end
        next_cycle();
        sample();
        tests_run++;
        if (bus_if.bus_req_valid !== 1'b1 || bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 32'h100 ||
            bus_if.bus_be !== 4'b1111 || bus_if.bus_wdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL sw_bus: valid=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000100 1111 deadbeef",
                     bus_if.bus_req_valid, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata);
        end
        tests_run++;
        if (access_done !== 1'b1 || mem_stall !== 1'b0 || bus_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_done: done=%b stall=%b err=%b want 1 0 0", access_done, mem_stall, bus_error);
        end
        next_cycle();
        dmem_we = 1'b0; bus_if.bus_req_ready = 1'b0;
        sample();
        tests_run++;
        if (dbg_state !== 3'd0 || bus_if.bus_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_after: state=%0d valid=%b want 0 0", dbg_state, bus_if.bus_req_valid);
        end
    endtask

    // Store byte with mem_read also high: the store must win.
    task automatic test_store_byte();
        next_cycle();
        dmem_we = 1'b1; mem_read = 1'b1; dmem_addr = 32'h103; dmem_wdata = 32'h000000A5;
        dmem_be = 4'b1000; dmem_funct3 = 3'b000; bus_if.bus_req_ready = 1'b1;
        next_cycle();
        sample();
        tests_run++;
        if (bus_if.bus_wdata !== 32'hA5A5A5A5 || bus_if.bus_be !== 4'b1000 || bus_if.bus_we !== 1'b1 ||
            bus_if.bus_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL sb_bus: wdata=%h be=%b we=%b addr=%h want a5a5a5a5 1000 1 00000100",
                     bus_if.bus_wdata, bus_if.bus_be, bus_if.bus_we, bus_if.bus_addr);
        end
        tests_run++;
        if (access_done !== 1'b1 || mem_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_done: done=%b stall=%b want 1 0", access_done, mem_stall);
        end
        next_cycle();
        dmem_wdata = 32'h0000BEEF; dmem_funct3 = 3'b001; dmem_be = 4'b1100; dmem_addr = 32'h102; mem_read = 1'b0;
        sample();
        tests_run++;
        if (bus_if.bus_wdata !== 32'hBEEFBEEF) begin
            tests_failed++;
            $display("FAIL sh_lanes: wdata=%h want beefbeef", bus_if.bus_wdata);
        end
        next_cycle();
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_load_extract();
        logic [31:0] addr_t [7] = '{32'h101, 32'h102, 32'h102, 32'h103, 32'h100, 32'h100, 32'h100};
        logic [2:0]  f3_t   [7] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000, 3'b001, 3'b011};
        logic [31:0] rd_t   [7] = '{32'h00008000, 32'h80010000, 32'h80010000, 32'h80010000,
                                    32'h0000007F, 32'h1234F00D, 32'hFFFFFFFF};
        logic [31:0] exp_t  [7] = '{32'hFFFFFF80, 32'h00008001, 32'hFFFF8001, 32'h00000080,
                                    32'h0000007F, 32'hFFFFF00D, 32'h00000000};
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            mem_read = 1'b1; dmem_addr = addr_t[i]; dmem_funct3 = f3_t[i];
            bus_if.bus_req_ready = 1'b1; bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = rd_t[i];
            sample();
            tests_run++;
            if (mem_stall !== 1'b1) begin tests_failed++; $display("FAIL load%0d_c0_stall: got %b want 1", i, mem_stall); end
            next_cycle();
            sample();
            tests_run++;
            if (bus_if.bus_req_valid !== 1'b1 || bus_if.bus_we !== 1'b0 || bus_if.bus_be !== 4'b1111 ||
                access_done !== 1'b0 || mem_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL load%0d_c1: valid=%b we=%b be=%b done=%b stall=%b want 1 0 1111 0 1",
                         i, bus_if.bus_req_valid, bus_if.bus_we, bus_if.bus_be, access_done, mem_stall);
            end
            next_cycle();
            sample();
            tests_run++;
            if (access_done !== 1'b1 || mem_stall !== 1'b0 || load_data !== exp_t[i] || dbg_state !== 3'd3) begin
                tests_failed++;
                $display("FAIL load%0d_done: done=%b stall=%b data=%h state=%0d want 1 0 %h 3",
                         i, access_done, mem_stall, load_data, dbg_state, exp_t[i]);
            end
            next_cycle();
            clear_inputs();
            sample();
            tests_run++;
            if (load_data !== exp_t[i] || access_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL load%0d_hold: data=%h done=%b want %h 0", i, load_data, access_done, exp_t[i]);
            end
        end
    endtask

    task automatic test_slow_load();
        next_cycle();
        mem_read = 1'b1; dmem_addr = 32'h200; dmem_funct3 = 3'b010;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            // A response before the handshake must be ignored.
            bus_if.bus_rsp_valid = (i == 2);
            bus_if.bus_rdata     = 32'hBAD0BAD0;
            sample();
            tests_run++;
            if (bus_if.bus_req_valid !== 1'b1 || bus_if.bus_addr !== 32'h200 || mem_stall !== 1'b1 || dbg_state !== 3'd1) begin
                tests_failed++;
                $display("FAIL slow_wait%0d: valid=%b addr=%h stall=%b state=%0d want 1 00000200 1 1",
                         i, bus_if.bus_req_valid, bus_if.bus_addr, mem_stall, dbg_state);
            end
        end
        next_cycle();
        bus_if.bus_rsp_valid = 1'b0; bus_if.bus_req_ready = 1'b1;
        sample();
        tests_run++;
        if (bus_if.bus_req_valid !== 1'b1 || access_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL slow_hs: valid=%b done=%b want 1 0", bus_if.bus_req_valid, access_done);
        end
        next_cycle();
        bus_if.bus_req_ready = 1'b0;
        sample();
        tests_run++;
        if (bus_if.bus_req_valid !== 1'b0 || dbg_state !== 3'd2 || mem_stall !== 1'b1 || access_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL slow_resp: valid=%b state=%0d stall=%b done=%b want 0 2 1 0",
                     bus_if.bus_req_valid, dbg_state, mem_stall, access_done);
        end
        next_cycle();
        bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = 32'h12345678;
        sample();
        tests_run++;
        if (access_done !== 1'b0 || mem_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL slow_rsp_cycle: done=%b stall=%b want 0 1", access_done, mem_stall);
        end
        next_cycle();
        bus_if.bus_rdata = 32'hFFFFFFFF;
        sample();
        tests_run++;
        if (access_done !== 1'b1 || mem_stall !== 1'b0 || load_data !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL slow_done: done=%b stall=%b data=%h want 1 0 12345678", access_done, mem_stall, load_data);
        end
        next_cycle();
        clear_inputs();
        sample();
        tests_run++;
        if (load_data !== 32'h12345678 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL slow_after: data=%h state=%0d want 12345678 0", load_data, dbg_state);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        mem_read = 1'b1; dmem_addr = 32'h300; dmem_funct3 = 3'b010;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            sample();
            tests_run++;
            if (bus_if.bus_req_valid !== 1'b1 || bus_error !== 1'b0 || access_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_wait%0d: valid=%b err=%b done=%b want 1 0 0", i, bus_if.bus_req_valid, bus_error, access_done);
            end
        end
        next_cycle();
        sample();
        tests_run++;
        if (bus_error !== 1'b1 || access_done !== 1'b1 || bus_if.bus_req_valid !== 1'b0 ||
            load_data !== 32'h0 || mem_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: err=%b done=%b valid=%b data=%h stall=%b want 1 1 0 0 0",
                     bus_error, access_done, bus_if.bus_req_valid, load_data, mem_stall);
        end
        next_cycle();
        mem_read = 1'b0;
        sample();
        tests_run++;
        if (dbg_state !== 3'd0 || bus_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_after: state=%0d err=%b want 0 0", dbg_state, bus_error);
        end
    endtask

    task automatic test_reset_in_resp();
        next_cycle();
        mem_read = 1'b1; dmem_addr = 32'h400; dmem_funct3 = 3'b010; bus_if.bus_req_ready = 1'b1;
        next_cycle();
        next_cycle();
        bus_if.bus_req_ready = 1'b0; rst = 1'b1; bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = 32'h55;
        sample();
        tests_run++;
        if (dbg_state !== 3'd2 || access_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_resp_cycle: state=%0d done=%b want 2 0", dbg_state, access_done);
        end
        next_cycle();
        rst = 1'b0; clear_inputs();
        sample();
        tests_run++;
        if (dbg_state !== 3'd0 || access_done !== 1'b0 || bus_error !== 1'b0 || load_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_resp_after: state=%0d done=%b err=%b data=%h want 0 0 0 0",
                     dbg_state, access_done, bus_error, load_data);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        dmem_we = 1'b1; dmem_addr = 32'h500; dmem_wdata = 32'h11223344; dmem_be = 4'b1111;
        dmem_funct3 = 3'b010; bus_if.bus_req_ready = 1'b1;
        next_cycle();
        sample();
        tests_run++;
        if (access_done !== 1'b1 || bus_if.bus_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_store: done=%b we=%b want 1 1", access_done, bus_if.bus_we);
        end
        next_cycle();
        dmem_we = 1'b0; mem_read = 1'b1; dmem_addr = 32'h501; dmem_funct3 = 3'b100;
        bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = 32'h0000AB00;
        sample();
        tests_run++;
        if (mem_stall !== 1'b1 || dbg_state !== 3'd0 || bus_if.bus_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: stall=%b state=%0d valid=%b want 1 0 0", mem_stall, dbg_state, bus_if.bus_req_valid);
        end
        next_cycle();
        next_cycle();
        sample();
        tests_run++;
        if (access_done !== 1'b1 || load_data !== 32'h000000AB) begin
            tests_failed++;
            $display("FAIL b2b_load: done=%b data=%h want 1 000000ab", access_done, load_data);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_misaligned_word();
        next_cycle();
        mem_read = 1'b1; dmem_addr = 32'h102; dmem_funct3 = 3'b010;
        bus_if.bus_req_ready = 1'b1; bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = 32'hCAFEF00D;
        next_cycle();
        sample();
`ifdef MISALIGN_TRAP_EN
        tests_run++;
        if (bus_if.bus_req_valid !== 1'b0 || bus_error !== 1'b1 || access_done !== 1'b1 || load_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL misalign_trap: valid=%b err=%b done=%b data=%h want 0 1 1 0",
                     bus_if.bus_req_valid, bus_error, access_done, load_data);
        end
        next_cycle();
        clear_inputs();
`else
        tests_run++;
        if (bus_if.bus_req_valid !== 1'b1 || bus_if.bus_addr !== 32'h100 || bus_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_pass_req: valid=%b addr=%h err=%b want 1 00000100 0",
                     bus_if.bus_req_valid, bus_if.bus_addr, bus_error);
        end
        next_cycle();
        sample();
        tests_run++;
        if (access_done !== 1'b1 || load_data !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL misalign_pass_data: done=%b data=%h want 1 cafef00d", access_done, load_data);
        end
        next_cycle();
        clear_inputs();
`endif
        sample();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_extract();
        test_slow_load();
        test_timeout();
        test_reset_in_resp();
        test_back_to_back();
        test_misaligned_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
